pifo_sram_req_arbiter: RTL

//  Front-end controller for the PIFO SRAM top. Shares its single push port among NREQ requesters (round-robin)
//  and sequences pops under the PIFO's spacing rule; returns pop data with a valid strobe.

---
 rtl/pifo_sram_req_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pifo_sram_req_arbiter.sv
// Front-end controller for the PIFO SRAM: round-robin push arbitration across NREQ requesters,
// spaced pop sequencing with in-flight tracking, occupancy flags, start-up hold-off and drain.
module pifo_sram_req_arbiter #(
  parameter int NREQ     = 4,
  parameter int PTW      = 10,
  parameter int MTW      = 0,
  parameter int CAPACITY = 30,
  parameter int POP_LAT  = 1,
  parameter int POP_GAP  = 2,
  parameter int INIT_CYC = 8,
  localparam int EW      = PTW + MTW,
  localparam int CW      = $clog2(CAPACITY + 1)
) (
  input  logic               i_clk,
  input  logic               i_arst,
  input  logic [NREQ-1:0]    i_push_req,
  input  logic [NREQ*EW-1:0] i_push_data,
  output logic [NREQ-1:0]    o_push_gnt,
  input  logic               i_pop_req,
  output logic               o_pop_gnt,
  output logic               o_pop_valid,
  output logic [EW-1:0]      o_pop_data,
  input  logic               i_drain,
  output logic               o_drain_done,
  output logic               o_full,
  output logic               o_empty,
  output logic [CW-1:0]      o_count,
  output logic               o_pifo_push,
  output logic [EW-1:0]      o_pifo_push_data,
  output logic               o_pifo_pop,
  input  logic [EW-1:0]      i_pifo_pop_data
);

  localparam int          PW = $clog2(NREQ);
  localparam int          GW = $clog2(POP_GAP + 1);
  localparam int          IW = $clog2(INIT_CYC + 1);
  localparam int unsigned NR = NREQ;
  localparam int unsigned PL = POP_LAT;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     init_cnt_q;
  logic [CW-1:0]     count_q;
  logic [PW-1:0]     rr_ptr_q;
  logic [GW-1:0]     gap_q;
  logic [POP_LAT:0]  tok_q, tok_d;
  logic              pifo_push_q;
  logic [EW-1:0]     pifo_push_data_q;
  logic              pifo_pop_q;
  logic              pop_valid_q;
  logic [EW-1:0]     pop_data_q;

  logic              full, empty, pop_ok, in_flight;
  logic              push_found;
  logic [PW-1:0]     push_idx;
  logic              push_take;
  logic              pop_gnt, drain_pop, drain_done, pop_issue;
  logic [NREQ-1:0]   push_gnt;

  assign full      = (count_q == CW'(CAPACITY));
  assign empty     = (count_q == '0);
  assign pop_ok    = !empty && (gap_q == '0);
  assign in_flight = |tok_q;

  // First requester at or after the round-robin pointer.
  always_comb begin
    push_found = 1'b0;
    push_idx   = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (!push_found && i_push_req[PW'((32'(rr_ptr_q) + i) % NR)]) begin
        push_found = 1'b1;
        push_idx   = PW'((32'(rr_ptr_q) + i) % NR);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pop_gnt    = 1'b0;
    push_take  = 1'b0;
    drain_pop  = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == IW'(INIT_CYC - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A push is withheld in the i_drain cycle so pending requesters carry into DRAIN untouched.
        if (i_pop_req && pop_ok) pop_gnt = 1'b1;
        else if (!full && push_found && !i_drain) push_take = 1'b1;
        if (i_drain) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop_ok) begin
          drain_pop = 1'b1;
        end else if (empty && !in_flight) begin
          drain_done = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign pop_issue = pop_gnt | drain_pop;
  assign push_gnt  = push_take ? (NREQ'(1) << push_idx) : '0;

  always_comb begin
    tok_d    = '0;
    tok_d[0] = pop_issue;
    for (int unsigned i = 1; i <= PL; i++) tok_d[i] = tok_q[i-1];
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q          <= ST_INIT;
      init_cnt_q       <= '0;
      count_q          <= '0;
      rr_ptr_q         <= '0;
      gap_q            <= '0;
      tok_q            <= '0;
      pifo_push_q      <= 1'b0;
      pifo_push_data_q <= '0;
      pifo_pop_q       <= 1'b0;
      pop_valid_q      <= 1'b0;
      pop_data_q       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + 1'b1;

      if (push_take)      count_q <= count_q + 1'b1;
      else if (pop_issue) count_q <= count_q - 1'b1;

      if (push_take) rr_ptr_q <= (push_idx == PW'(NREQ - 1)) ? '0 : push_idx + 1'b1;

      if (pop_issue)         gap_q <= GW'(POP_GAP - 1);
      else if (gap_q != '0)  gap_q <= gap_q - 1'b1;

      tok_q       <= tok_d;
      pifo_push_q <= push_take;
      if (push_take) pifo_push_data_q <= i_push_data[int'(push_idx)*EW +: EW];
      pifo_pop_q  <= pop_issue;

      pop_valid_q <= tok_q[POP_LAT];
      if (tok_q[POP_LAT]) pop_data_q <= i_pifo_pop_data;
    end
  end

  assign o_push_gnt       = push_gnt;
  assign o_pop_gnt        = pop_gnt;
  assign o_pop_valid      = pop_valid_q;
  assign o_pop_data       = pop_data_q;
  assign o_drain_done     = drain_done;
  assign o_full           = full;
  assign o_empty          = empty;
  assign o_count          = count_q;
  assign o_pifo_push      = pifo_push_q;
  assign o_pifo_push_data = pifo_push_data_q;
  assign o_pifo_pop       = pifo_pop_q;

endmodule
